// File: rtl/dcache_if.sv
// dcache_if -- bundles the CPU-side and memory-side signals of the data cache.
//
// CPU side : dcache_addr_i, dcache_wdata_i, dcache_rreq_i, dcache_wsel_i (to cache)
//            dcache_data_o, stall_o                                   (from cache)
// Mem side : mem_rreq_o, mem_raddr_o, mem_wreq_o, mem_waddr_o, mem_wdata_o (from cache)
//            mem_rdata_i, mem_rvalid_i, mem_wready_i                    (to cache)
//
// Modports: slave  = the cache itself
//           master = the environment (CPU plus memory) driving the cache
interface dcache_if;
  logic [31:0]  dcache_addr_i;
  logic [31:0]  dcache_wdata_i;
  logic         dcache_rreq_i;
  logic         dcache_wsel_i;
  logic [31:0]  dcache_data_o;
  logic         stall_o;
  logic         mem_rreq_o;
  logic [31:0]  mem_raddr_o;
  logic [127:0] mem_rdata_i;
  logic         mem_rvalid_i;
  logic         mem_wreq_o;
  logic [31:0]  mem_waddr_o;
  logic [31:0]  mem_wdata_o;
  logic         mem_wready_i;

  modport slave (
    input  dcache_addr_i, dcache_wdata_i, dcache_rreq_i, dcache_wsel_i,
           mem_rdata_i, mem_rvalid_i, mem_wready_i,
    output dcache_data_o, stall_o, mem_rreq_o, mem_raddr_o,
           mem_wreq_o, mem_waddr_o, mem_wdata_o
  );

  modport master (
    output dcache_addr_i, dcache_wdata_i, dcache_rreq_i, dcache_wsel_i,
           mem_rdata_i, mem_rvalid_i, mem_wready_i,
    input  dcache_data_o, stall_o, mem_rreq_o, mem_raddr_o,
           mem_wreq_o, mem_waddr_o, mem_wdata_o
  );
endinterface

// File: rtl/dcache.sv
// dcache -- direct-mapped, write-through, no-write-allocate, blocking data cache.
// Geometry: 16 lines x 4 words; index = addr[7:4], word = addr[3:2], tag = addr[31:8].
//
// Ports:
//   clk  - sole clock, all state changes on the rising edge
//   rst  - asynchronous active-low reset; clears valid bits, forces IDLE
//   bus  - dcache_if.slave carrying the CPU request/response and the
//          memory refill / write-through handshakes
module dcache (
  input  logic    clk,
  input  logic    rst,
  dcache_if.slave bus
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] REFILL = 2'd1;
  localparam logic [1:0] WRITE  = 2'd2;

  logic [1:0]  state_q, state_d;
  logic        wrDone_q, wrDone_d;
  logic [29:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [15:0] valid_q, valid_d;
  logic [23:0] tagArray_q  [16];
  logic [31:0] dataArray_q [16][4];

  logic [3:0]  cpuIdx;
  logic [1:0]  cpuWord;
  logic [23:0] cpuTag;
  logic        cpuHit;
  logic [3:0]  opIdx;
  logic [1:0]  opWord;
  logic [23:0] opTag;
  logic        opHit;
  logic        stall;
  logic [31:0] rdata;
  logic        unusedAddrBits;

  assign cpuIdx  = bus.dcache_addr_i[7:4];
  assign cpuWord = bus.dcache_addr_i[3:2];
  assign cpuTag  = bus.dcache_addr_i[31:8];
  assign cpuHit  = valid_q[cpuIdx] && (tagArray_q[cpuIdx] == cpuTag);

  // addr_q holds the word address (addr[31:2]) of the operation in flight,
  // so memory-side addresses stay stable even if the CPU misbehaves.
  assign opIdx  = addr_q[5:2];
  assign opWord = addr_q[1:0];
  assign opTag  = addr_q[29:6];
  assign opHit  = valid_q[opIdx] && (tagArray_q[opIdx] == opTag);

  // Byte offset is irrelevant for word accesses.
  assign unusedAddrBits = ^bus.dcache_addr_i[1:0];

  always_comb begin
    state_d  = state_q;
    wrDone_d = 1'b0;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    valid_d  = valid_q;
    stall    = 1'b0;
    rdata    = 32'd0;
    unique case (state_q)
      IDLE: begin
        // The cycle right after a write retires lets the CPU drop a still-high
        // wsel without starting a second write.
        if (wrDone_q && bus.dcache_wsel_i) begin
          stall = 1'b0;
        end else if (bus.dcache_wsel_i) begin
          stall   = 1'b1;
          state_d = WRITE;
          addr_d  = bus.dcache_addr_i[31:2];
          wdata_d = bus.dcache_wdata_i;
        end else if (bus.dcache_rreq_i) begin
          if (cpuHit) begin
            rdata = dataArray_q[cpuIdx][cpuWord];
          end else begin
            stall   = 1'b1;
            state_d = REFILL;
            addr_d  = bus.dcache_addr_i[31:2];
          end
        end
      end
      REFILL: begin
        stall = 1'b1;
        if (bus.mem_rvalid_i) begin
          valid_d[opIdx] = 1'b1;
          state_d        = IDLE;
        end
      end
      WRITE: begin
        stall = 1'b1;
        if (bus.mem_wready_i) begin
          wrDone_d = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      wrDone_q <= 1'b0;
      addr_q   <= 30'd0;
      wdata_q  <= 32'd0;
      valid_q  <= 16'd0;
    end else begin
      state_q  <= state_d;
      wrDone_q <= wrDone_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      valid_q  <= valid_d;
    end
  end

  // Tag/data storage carries no reset; validity alone decides a hit.
  // A write updates the cached word only if the line already holds it.
  always_ff @(posedge clk) begin
    if (state_q == REFILL && bus.mem_rvalid_i) begin
      tagArray_q[opIdx] <= opTag;
      for (int w = 0; w < 4; w++) begin
        dataArray_q[opIdx][w] <= bus.mem_rdata_i[32*w +: 32];
      end
    end else if (state_q == WRITE && bus.mem_wready_i && opHit) begin
      dataArray_q[opIdx][opWord] <= wdata_q;
    end
  end

  // Combinational outputs are forced low while reset is held.
  assign bus.stall_o       = stall & rst;
  assign bus.dcache_data_o = rst ? rdata : 32'd0;
  assign bus.mem_rreq_o    = (state_q == REFILL);
  assign bus.mem_raddr_o   = (state_q == REFILL) ? {addr_q[29:2], 4'b0000} : 32'd0;
  assign bus.mem_wreq_o    = (state_q == WRITE);
  assign bus.mem_waddr_o   = (state_q == WRITE) ? {addr_q, 2'b00} : 32'd0;
  assign bus.mem_wdata_o   = (state_q == WRITE) ? wdata_q : 32'd0;

endmodule

// File: tb/tb_dcache.sv
// tb_dcache -- self-checking bench for dcache.
// The reference model tracks only which memory lines are resident (valid/tag
// per index) plus a sparse word-addressed memory image. Because the cache is
// write-through, any hit must return exactly the current memory word.
module tb_dcache;

  logic clk = 1'b0;
  logic rst;

  dcache_if bus ();

  dcache dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int testCount = 0;
  int failCount = 0;

  logic [31:0] memModel [int unsigned];
  bit          mValid [16];
  logic [23:0] mTag   [16];

  function automatic logic [31:0] memRead(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    if (memModel.exists(w)) return memModel[w];
    return (w * 32'h9E37_79B1) + 32'h1357_2468;
  endfunction

  function automatic bit modelHit(input logic [31:0] a);
    return mValid[a[7:4]] && (mTag[a[7:4]] == a[31:8]);
  endfunction

  task automatic modelReset();
    foreach (mValid[i]) mValid[i] = 1'b0;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic rreq, input logic wsel,
                               input logic [31:0] addr, input logic [31:0] wdata);
    bus.dcache_rreq_i  = rreq;
    bus.dcache_wsel_i  = wsel;
    bus.dcache_addr_i  = addr;
    bus.dcache_wdata_i = wdata;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, "/idleStall"}, 32'(bus.stall_o), 32'd0);
    checkOutput({tag, "/idleData"}, bus.dcache_data_o, 32'd0);
    checkOutput({tag, "/idleRreq"}, 32'(bus.mem_rreq_o), 32'd0);
    checkOutput({tag, "/idleWreq"}, 32'(bus.mem_wreq_o), 32'd0);
  endtask

  // Read transaction: starts just after a rising edge, ends just after one.
  task automatic doRead(input logic [31:0] a, input string tag);
    logic [31:0] lineA;
    int          lat;
    lineA = {a[31:4], 4'h0};
    applyStimulus(1'b1, 1'b0, a, $urandom);
    @(negedge clk);
    if (!modelHit(a)) begin
      checkOutput({tag, "/missStall"}, 32'(bus.stall_o), 32'd1);
      checkOutput({tag, "/missNoReqYet"}, 32'(bus.mem_rreq_o), 32'd0);
      lat = $urandom_range(0, 3);
      for (int i = 0; i < lat; i++) begin
        nextCycle();
        @(negedge clk);
        checkOutput({tag, "/refillReq"}, 32'(bus.mem_rreq_o), 32'd1);
        checkOutput({tag, "/refillAddr"}, bus.mem_raddr_o, lineA);
        checkOutput({tag, "/refillStall"}, 32'(bus.stall_o), 32'd1);
      end
      nextCycle();
      bus.mem_rvalid_i = 1'b1;
      bus.mem_rdata_i  = {memRead(lineA + 32'd12), memRead(lineA + 32'd8),
                          memRead(lineA + 32'd4), memRead(lineA)};
      @(negedge clk);
      checkOutput({tag, "/rvalidReq"}, 32'(bus.mem_rreq_o), 32'd1);
      checkOutput({tag, "/rvalidAddr"}, bus.mem_raddr_o, lineA);
      checkOutput({tag, "/rvalidStall"}, 32'(bus.stall_o), 32'd1);
      nextCycle();
      bus.mem_rvalid_i = 1'b0;
      bus.mem_rdata_i  = {$urandom, $urandom, $urandom, $urandom};
      mValid[a[7:4]] = 1'b1;
      mTag[a[7:4]]   = a[31:8];
      @(negedge clk);
    end
    checkOutput({tag, "/hitStall"}, 32'(bus.stall_o), 32'd0);
    checkOutput({tag, "/hitData"}, bus.dcache_data_o, memRead(a));
    checkOutput({tag, "/hitNoReq"}, 32'(bus.mem_rreq_o), 32'd0);
    nextCycle();
    applyStimulus(1'b0, 1'b0, $urandom, $urandom);
  endtask

  // Write-through transaction; occasionally holds rreq too, which must
  // still be treated as a write.
  task automatic doWrite(input logic [31:0] a, input logic [31:0] d, input string tag);
    logic [31:0] wAddr;
    int          lat;
    logic        both;
    wAddr = {a[31:2], 2'b00};
    both  = 1'($urandom_range(0, 1));
    applyStimulus(both, 1'b1, a, d);
    @(negedge clk);
    checkOutput({tag, "/wrStall"}, 32'(bus.stall_o), 32'd1);
    checkOutput({tag, "/wrNoReqYet"}, 32'(bus.mem_wreq_o), 32'd0);
    lat = $urandom_range(0, 3);
    for (int i = 0; i < lat; i++) begin
      nextCycle();
      @(negedge clk);
      checkOutput({tag, "/wrReq"}, 32'(bus.mem_wreq_o), 32'd1);
      checkOutput({tag, "/wrAddr"}, bus.mem_waddr_o, wAddr);
      checkOutput({tag, "/wrData"}, bus.mem_wdata_o, d);
      checkOutput({tag, "/wrNoRefill"}, 32'(bus.mem_rreq_o), 32'd0);
    end
    nextCycle();
    bus.mem_wready_i = 1'b1;
    @(negedge clk);
    checkOutput({tag, "/wreadyReq"}, 32'(bus.mem_wreq_o), 32'd1);
    checkOutput({tag, "/wreadyAddr"}, bus.mem_waddr_o, wAddr);
    checkOutput({tag, "/wreadyStall"}, 32'(bus.stall_o), 32'd1);
    nextCycle();
    bus.mem_wready_i = 1'b0;
    memModel[wAddr] = d;
    @(negedge clk);
    checkOutput({tag, "/retireStall"}, 32'(bus.stall_o), 32'd0);
    checkOutput({tag, "/retireNoReq"}, 32'(bus.mem_wreq_o), 32'd0);
    nextCycle();
    applyStimulus(1'b0, 1'b0, $urandom, $urandom);
    @(negedge clk);
    checkIdle({tag, "/afterWrite"});
    nextCycle();
  endtask

  initial begin
    logic [31:0] a;
    rst = 1'b0;
    bus.mem_rdata_i  = '0;
    bus.mem_rvalid_i = 1'b0;
    bus.mem_wready_i = 1'b0;
    applyStimulus(1'b1, 1'b0, 32'h0000_0104, 32'd0);
    modelReset();

    // Outputs stay quiet while reset is held, even with a request pending.
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("resetStall", 32'(bus.stall_o), 32'd0);
    checkOutput("resetRreq", 32'(bus.mem_rreq_o), 32'd0);
    checkOutput("resetWreq", 32'(bus.mem_wreq_o), 32'd0);
    checkOutput("resetData", bus.dcache_data_o, 32'd0);
    applyStimulus(1'b0, 1'b0, 32'd0, 32'd0);
    rst = 1'b1;
    nextCycle();
    @(negedge clk);
    checkIdle("postReset");
    nextCycle();

    memModel[32'h0000_0100] = 32'h0000_AAAA;
    memModel[32'h0000_0104] = 32'h0000_BBBB;
    memModel[32'h0000_0108] = 32'h0000_CCCC;
    memModel[32'h0000_010C] = 32'h0000_DDDD;

    doRead(32'h0000_0104, "rdMiss104");
    doRead(32'h0000_010C, "rdHit10C");
    doWrite(32'h0000_0108, 32'h1234_5678, "wrHit108");
    doRead(32'h0000_0108, "rdAfterWr108");
    doWrite(32'h0000_0200, 32'hCAFE_F00D, "wrMiss200");
    doRead(32'h0000_0200, "rdMiss200");
    doRead(32'h0000_1104, "rdConflict1104");
    doRead(32'h0000_0104, "rdEvicted104");

    // Stray memory handshakes while idle must not touch the cache.
    bus.mem_rvalid_i = 1'b1;
    bus.mem_wready_i = 1'b1;
    bus.mem_rdata_i  = {4{32'hDEAD_BEEF}};
    nextCycle();
    bus.mem_rvalid_i = 1'b0;
    bus.mem_wready_i = 1'b0;
    @(negedge clk);
    checkIdle("strayPulse");
    nextCycle();
    doRead(32'h0000_0300, "rdAfterStray");

    // Reset pulsed mid-refill aborts it; the line stays invalid.
    applyStimulus(1'b1, 1'b0, 32'h0000_0404, 32'd0);
    nextCycle();
    @(negedge clk);
    checkOutput("abortRefillReq", 32'(bus.mem_rreq_o), 32'd1);
    #2 rst = 1'b0;
    #1;
    checkOutput("abortRefillStall", 32'(bus.stall_o), 32'd0);
    checkOutput("abortRefillRreq", 32'(bus.mem_rreq_o), 32'd0);
    modelReset();
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 32'd0, 32'd0);
    rst = 1'b1;
    nextCycle();
    doRead(32'h0000_0404, "rdAfterAbort");
    doRead(32'h0000_010C, "rdAfterAbortOld");

    // Reset pulsed mid-write aborts it; memory never saw the store.
    applyStimulus(1'b0, 1'b1, 32'h0000_0104, 32'h5555_AAAA);
    nextCycle();
    @(negedge clk);
    checkOutput("abortWriteReq", 32'(bus.mem_wreq_o), 32'd1);
    #2 rst = 1'b0;
    #1;
    checkOutput("abortWriteStall", 32'(bus.stall_o), 32'd0);
    checkOutput("abortWriteWreq", 32'(bus.mem_wreq_o), 32'd0);
    modelReset();
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 32'd0, 32'd0);
    rst = 1'b1;
    nextCycle();
    doRead(32'h0000_0104, "rdAfterWrAbort");

    // Random traffic over a few tags so hits, conflicts and write hits mix.
    for (int n = 0; n < 200; n++) begin
      a = {22'd0, 2'($urandom_range(0, 3)), 4'($urandom), 2'($urandom), 2'($urandom)};
      if ($urandom_range(0, 9) < 6) doRead(a, "rndRead");
      else doWrite(a, $urandom, "rndWrite");
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/dcache.md
DCACHE -- requirements
Module: dcache

Interface
REQ-001 The module SHALL have no parameters; geometry is fixed: direct-mapped, 16 lines x 4 words (16 B/line); index = addr[7:4], word = addr[3:2], tag = addr[31:8]; addr[1:0] ignored.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-low.
REQ-004 dcache_addr_i  input  32  CPU byte address for read or write.
REQ-005 dcache_wdata_i  input  32  CPU store data.
REQ-006 dcache_rreq_i  input  1  CPU read request, level, held until stall_o low.
REQ-007 dcache_wsel_i  input  1  CPU write request, level, held until stall_o low.
REQ-008 dcache_data_o  output  32  read data to CPU; valid when dcache_rreq_i=1 and stall_o=0.
REQ-009 stall_o  output  1  CPU must hold request and inputs while high.
REQ-010 mem_rreq_o  output  1  line refill request to memory.
REQ-011 mem_raddr_o  output  32  line-aligned refill address, {addr[31:4],4'b0}.
REQ-012 mem_rdata_i  input  128  refill line; word0 in bits [31:0].
REQ-013 mem_rvalid_i  input  1  one-cycle pulse; mem_rdata_i valid.
REQ-014 mem_wreq_o  output  1  write-through request.
REQ-015 mem_waddr_o  output  32  write address, {addr[31:2],2'b0}.
REQ-016 mem_wdata_o  output  32  write data.
REQ-017 mem_wready_i  input  1  one-cycle pulse; memory accepted the write.

Function
REQ-018 States: IDLE, REFILL, WRITE; policy is write-through, no-write-allocate, blocking (one outstanding operation).
REQ-019 Hit = valid[index] AND tag_array[index]==addr[31:8]; evaluated combinationally in IDLE.
REQ-020 IDLE, rreq=1, wsel=0, hit: dcache_data_o = selected word in the same cycle, stall_o=0, no state change (zero-wait hit).
REQ-021 IDLE, rreq=1, wsel=0, miss: stall_o=1 combinationally; next state REFILL.
REQ-022 REFILL: mem_rreq_o=1, mem_raddr_o held stable, stall_o=1; on mem_rvalid_i, write the line, set tag and valid, and return to IDLE; the request then hits (miss latency = memory latency + 2 cycles).
REQ-023 IDLE, wsel=1: stall_o=1; next state WRITE; wsel has priority when rreq and wsel are both high (treated as a write).
REQ-024 WRITE: mem_wreq_o=1, mem_waddr_o/mem_wdata_o stable, stall_o=1; on mem_wready_i, if the address hits, update that cached word; return to IDLE with stall_o=0 for exactly that cycle so the CPU can retire the store.
REQ-025 In IDLE the first cycle after completing a write ignores a still-high wsel_i (CPU must drop it); then normal operation resumes.
REQ-026 Write miss SHALL NOT allocate or change any valid/tag.
REQ-027 IDLE with no request: stall_o=0, mem_rreq_o=0, mem_wreq_o=0; dcache_data_o = 0 when not reading.
REQ-028 mem_rvalid_i outside REFILL and mem_wready_i outside WRITE SHALL be ignored.

Reset
REQ-029 rst low SHALL asynchronously clear all 16 valid bits and force IDLE; all outputs 0 while in reset; data/tag arrays need no reset.
REQ-030 Reset asserted mid-REFILL or mid-WRITE SHALL abort the operation; the line is not marked valid.

Verification
REQ-031 After reset, read 0x0000_0104 with memory line 0x0000_0100 = {0xDDDD,0xCCCC,0xBBBB,0xAAAA} (word3..word0) -> stall, mem_rreq_o with mem_raddr_o=0x0000_0100, then dcache_data_o=0x0000_BBBB with stall_o=0.
REQ-032 Immediate re-read of 0x0000_010C -> 0x0000_DDDD the same cycle, no mem_rreq_o.
REQ-033 Write 0x1234_5678 to 0x0000_0108 (hit) -> mem_wreq_o with mem_waddr_o=0x0000_0108; after mem_wready_i, reading 0x0000_0108 returns 0x1234_5678 without refill.
REQ-034 Write to 0x0000_0200 (miss) then read 0x0000_0200 -> the read misses and refills from 0x0000_0200.
REQ-035 Read 0x0000_1104 (same index 0, different tag) after REQ-031 -> miss, refill replaces line; a re-read of 0x0000_0104 then misses.
REQ-036 rst pulsed low during REFILL -> stall_o, mem_rreq_o drop immediately; a later read of the same address misses.
